// File: rtl/collision_pkg.sv
// Shared types and helpers for the sprite collision event manager.
package collision_pkg;

  localparam int DEF_N_OBJ   = 8;
  localparam int DEF_COORD_W = 11;

  // Number of unordered sprite pairs for n channels.
  function automatic int npairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Flat index of pair (i,j), i<j, in row-major upper-triangle order.
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - i * (i + 1) / 2 + (j - i - 1);
  endfunction

  // Width of a pair index; never narrower than one bit.
  function automatic int pair_w(input int n);
    return (npairs(n) <= 1) ? 1 : $clog2(npairs(n));
  endfunction

  localparam int PAIR_W = pair_w(DEF_N_OBJ);

  // Event record for the default configuration; the top builds its own
  // record type sized to its parameters and hands it to the FIFO.
  typedef struct packed {
    logic [PAIR_W-1:0]      pair;
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
  } collision_evt_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/collision_event_fifo.sv
// First-word fall-through FIFO of collision events.
// Push side sees 'full', which already accounts for a same-cycle pop,
// so a full FIFO still takes a push while the consumer drains the head.
module collision_event_fifo
  import collision_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type evt_t = collision_evt_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  evt_t pushData,
  output logic full,
  output logic valid,
  input  logic ready,
  output evt_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  evt_t             mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             pop;
  logic             doPush;

  assign valid  = (count != '0);
  assign pop    = valid & ready;
  assign full   = (count == (PTR_W + 1)'(DEPTH)) & ~pop;
  assign doPush = push & ~full;
  assign head   = valid ? mem[rdPtr] : '0;

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({doPush, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/collision_event_manager.sv
// Per-pixel pairwise sprite overlap detection, per-frame accumulation and
// serialisation of new pair events into a valid/ready event FIFO.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no scan in progress, waiting for the next frame boundary
// SCAN  | walking pair indices, pushing pending events into the FIFO
module collision_event_manager
  import collision_pkg::*;
#(
  parameter int                         N_OBJ      = 8,
  parameter logic [npairs(N_OBJ)-1:0]   PAIR_MASK  = '1,
  parameter int                         FIFO_DEPTH = 8,
  parameter int                         COORD_W    = 11,
  parameter bit                         EDGE_MODE  = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_OBJ-1:0]             drawReq,
  input  logic [COORD_W-1:0]           pixelX,
  input  logic [COORD_W-1:0]           pixelY,
  input  logic                         startOfFrame,
  output logic [npairs(N_OBJ)-1:0]     collisionNow,
  output logic [npairs(N_OBJ)-1:0]     frameCollision,
  output logic                         evtValid,
  input  logic                         evtReady,
  output logic [pair_w(N_OBJ)-1:0]     evtPair,
  output logic [COORD_W-1:0]           evtX,
  output logic [COORD_W-1:0]           evtY,
  output logic                         evtOverflow,
  input  logic                         clearOverflow
);

  localparam int NPAIRS = npairs(N_OBJ);
  localparam int PW     = pair_w(N_OBJ);

  typedef struct packed {
    logic [PW-1:0]      pair;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } evt_t;

  logic [NPAIRS-1:0]  pairHit;
  logic [COORD_W-1:0] pixDX;
  logic [COORD_W-1:0] pixDY;
  logic [NPAIRS-1:0]  acc;
  logic [NPAIRS-1:0]  snap;
  logic [NPAIRS-1:0]  firstHit;
  logic [COORD_W-1:0] hitX  [NPAIRS];
  logic [COORD_W-1:0] hitY  [NPAIRS];
  logic [COORD_W-1:0] snapX [NPAIRS];
  logic [COORD_W-1:0] snapY [NPAIRS];
  logic [NPAIRS-1:0]  pending;

  scan_state_t        state;
  scan_state_t        stateNext;
  logic [PW-1:0]      scanIdx;
  logic [PW-1:0]      idxNext;
  logic               curPending;
  logic               lastIdx;
  logic               pushReq;
  logic               pushDone;
  logic               ovfSet;

  evt_t               pushData;
  evt_t               headEvt;
  logic               fifoFull;

  // Pair overlap for every enabled i<j combination of channels.
  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_i
    for (genvar gj = gi + 1; gj < N_OBJ; gj++) begin : g_j
      localparam int P = pair_index(gi, gj, N_OBJ);
      assign pairHit[P] = drawReq[gi] & drawReq[gj] & PAIR_MASK[P];
    end
  end

  // Stage 1: register the overlap vector with its pixel coordinate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collisionNow <= '0;
      pixDX        <= '0;
      pixDY        <= '0;
    end else begin
      collisionNow <= pairHit;
      pixDX        <= pixelX;
      pixDY        <= pixelY;
    end
  end

  // A hit on the boundary cycle still belongs to the closing frame.
  assign snap     = acc | collisionNow;
  assign firstHit = collisionNow & ~acc;

  // Sticky per-frame accumulation, first-hit capture and frame snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc            <= '0;
      frameCollision <= '0;
      for (int p = 0; p < NPAIRS; p++) begin
        hitX[p]  <= '0;
        hitY[p]  <= '0;
        snapX[p] <= '0;
        snapY[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPAIRS; p++) begin
        if (firstHit[p]) begin
          hitX[p] <= pixDX;
          hitY[p] <= pixDY;
        end
      end
      if (startOfFrame) begin
        acc            <= '0;
        frameCollision <= snap;
        for (int p = 0; p < NPAIRS; p++) begin
          snapX[p] <= firstHit[p] ? pixDX : hitX[p];
          snapY[p] <= firstHit[p] ? pixDY : hitY[p];
        end
      end else begin
        acc <= snap;
      end
    end
  end

  assign curPending = pending[scanIdx];
  assign lastIdx    = (scanIdx == PW'(NPAIRS - 1));

  // Scanner state register and pair index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      scanIdx <= '0;
    end else begin
      state   <= stateNext;
      scanIdx <= idxNext;
    end
  end

  // Scanner next state: a frame boundary always restarts at index 0.
  always_comb begin
    stateNext = state;
    idxNext   = scanIdx;
    if (startOfFrame) begin
      stateNext = SCAN;
      idxNext   = '0;
    end else begin
      case (state)
        IDLE: ;
        SCAN: begin
          if (!curPending || !fifoFull) begin
            if (lastIdx) stateNext = IDLE;
            else         idxNext   = scanIdx + 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Scanner outputs: push the current pending pair unless a frame restarts.
  always_comb begin
    pushReq  = 1'b0;
    pushDone = 1'b0;
    ovfSet   = 1'b0;
    if (state == SCAN) begin
      pushReq  = curPending & ~startOfFrame;
      pushDone = pushReq & ~fifoFull;
      ovfSet   = startOfFrame & (|pending);
    end
  end

  // Pending bits are cleared as they are pushed, so leftovers mean lost events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if (startOfFrame) begin
      pending <= EDGE_MODE ? (snap & ~frameCollision) : snap;
    end else if (pushDone) begin
      pending[scanIdx] <= 1'b0;
    end
  end

  // Sticky overflow flag; a new loss beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              evtOverflow <= 1'b0;
    else if (ovfSet)        evtOverflow <= 1'b1;
    else if (clearOverflow) evtOverflow <= 1'b0;
  end

  assign pushData.pair = scanIdx;
  assign pushData.x    = snapX[scanIdx];
  assign pushData.y    = snapY[scanIdx];

  collision_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .evt_t (evt_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushReq),
    .pushData (pushData),
    .full     (fifoFull),
    .valid    (evtValid),
    .ready    (evtReady),
    .head     (headEvt)
  );

  assign evtPair = headEvt.pair;
  assign evtX    = headEvt.x;
  assign evtY    = headEvt.y;

endmodule

// File: tb/tb_collision_event_manager.sv
// Directed and randomized bench for collision_event_manager with N_OBJ=4.
// Instance A: edge reporting, depth 8, all pairs enabled.
// Instance B: level reporting, depth 2, pair 2 (channels 0,3) disabled.
module tb_collision_event_manager;

  localparam logic [5:0] MASK_A = 6'b111111;
  localparam logic [5:0] MASK_B = 6'b111011;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  drawReq;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame;
  logic        clearOverflow;
  logic        readyA, readyB;

  logic [5:0]  aNow, bNow, aFc, bFc;
  logic        aValid, bValid, aOverflow, bOverflow;
  logic [2:0]  aPair, bPair;
  logic [10:0] aX, aY, bX, bY;

  int nErr = 0;
  int nChecks = 0;
  int cyc = 0;

  logic [5:0]  mAcc [2];
  logic [5:0]  mPrev [2];
  logic [10:0] mFx [2][6];
  logic [10:0] mFy [2][6];
  logic [31:0] qA[$];
  logic [31:0] qB[$];
  int          popCycA[$];

  collision_event_manager #(
    .N_OBJ(4), .PAIR_MASK(MASK_A), .FIFO_DEPTH(8), .COORD_W(11), .EDGE_MODE(1'b1)
  ) dutA (
    .clk(clk), .reset(reset), .drawReq(drawReq), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .collisionNow(aNow), .frameCollision(aFc),
    .evtValid(aValid), .evtReady(readyA), .evtPair(aPair), .evtX(aX), .evtY(aY),
    .evtOverflow(aOverflow), .clearOverflow(clearOverflow)
  );

  collision_event_manager #(
    .N_OBJ(4), .PAIR_MASK(MASK_B), .FIFO_DEPTH(2), .COORD_W(11), .EDGE_MODE(1'b0)
  ) dutB (
    .clk(clk), .reset(reset), .drawReq(drawReq), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .collisionNow(bNow), .frameCollision(bFc),
    .evtValid(bValid), .evtReady(readyB), .evtPair(bPair), .evtX(bX), .evtY(bY),
    .evtOverflow(bOverflow), .clearOverflow(clearOverflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pairs of overlapping channels, enumerated i<j in ascending order.
  function automatic logic [5:0] pairsOf(input logic [3:0] d, input logic [5:0] m);
    logic [5:0] v = '0;
    int k = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++) begin
        v[k] = d[i] & d[j] & m[k];
        k++;
      end
    return v;
  endfunction

  function automatic logic [31:0] pk(input int p, input logic [10:0] x, input logic [10:0] y);
    return {7'd0, 3'(p), x, y};
  endfunction

  // Event monitors: every accepted head must match the model queue front.
  always @(negedge clk) begin
    if (!reset && aValid && readyA) begin
      nChecks++;
      assert (qA.size() != 0) else begin
        nErr++;
        $error("FAIL A_evt_extra observed pair=%0d expected no event", aPair);
      end
      if (qA.size() != 0) chk("A_evt", {7'd0, aPair, aX, aY}, qA.pop_front());
      popCycA.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (!reset && bValid && readyB) begin
      nChecks++;
      assert (qB.size() != 0) else begin
        nErr++;
        $error("FAIL B_evt_extra observed pair=%0d expected no event", bPair);
      end
      if (qB.size() != 0) chk("B_evt", {7'd0, bPair, bX, bY}, qB.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic modelClear();
    for (int k = 0; k < 2; k++) begin
      mAcc[k] = '0;
      mPrev[k] = '0;
    end
    qA.delete();
    qB.delete();
  endtask

  // One pixel with drawing requests; the registered overlap is checked.
  task automatic pixel(input logic [3:0] d, input logic [10:0] x, input logic [10:0] y);
    logic [5:0] v;
    drawReq = d; pixelX = x; pixelY = y;
    for (int k = 0; k < 2; k++) begin
      v = pairsOf(d, (k == 0) ? MASK_A : MASK_B);
      for (int p = 0; p < 6; p++)
        if (v[p] && !mAcc[k][p]) begin
          mAcc[k][p] = 1'b1; mFx[k][p] = x; mFy[k][p] = y;
        end
    end
    step();
    chk("A_now", aNow, pairsOf(d, MASK_A));
    chk("B_now", bNow, pairsOf(d, MASK_B));
    drawReq = '0;
  endtask

  // Frame boundary: model decides reported pairs; capB limits B's accepted events.
  task automatic sof(input int capB);
    logic [5:0] fc, pend;
    logic [5:0] eFc [2];
    int n;
    for (int k = 0; k < 2; k++) begin
      fc = mAcc[k];
      pend = (k == 0) ? (fc & ~mPrev[k]) : fc;
      n = 0;
      for (int p = 0; p < 6; p++)
        if (pend[p]) begin
          if (k == 0) qA.push_back(pk(p, mFx[k][p], mFy[k][p]));
          else if (n < capB) qB.push_back(pk(p, mFx[k][p], mFy[k][p]));
          n++;
        end
      eFc[k] = fc;
      mPrev[k] = fc;
      mAcc[k] = '0;
    end
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    chk("A_frameCollision", aFc, eFc[0]);
    chk("B_frameCollision", bFc, eFc[1]);
  endtask

  initial begin
    reset = 1'b1; drawReq = '0; pixelX = '0; pixelY = '0;
    startOfFrame = 1'b0; clearOverflow = 1'b0; readyA = 1'b1; readyB = 1'b1;
    modelClear();
    popCycA.delete();
    repeat (3) step();
    chk("rst_A_now", aNow, 0);
    chk("rst_A_fc", aFc, 0);
    chk("rst_A_valid", aValid, 0);
    chk("rst_A_head", {aPair, aX, aY}, 0);
    chk("rst_A_ovf", aOverflow, 0);
    chk("rst_B_valid", bValid, 0);
    reset = 1'b0;
    step();

    // Frame 1: single overlap, head held until accepted.
    readyA = 1'b0;
    pixel(4'b0011, 11'd100, 11'd50);
    pixel(4'b0011, 11'd101, 11'd50);
    sof(99);
    repeat (5) step();
    chk("t1_valid", aValid, 1);
    chk("t1_head", {7'd0, aPair, aX, aY}, pk(0, 11'd100, 11'd50));
    repeat (3) step();
    chk("t1_valid_held", aValid, 1);
    readyA = 1'b1;
    repeat (3) step();
    chk("t1_A_drained", qA.size(), 0);
    chk("t1_A_empty", aValid, 0);

    // Frame 2: same overlap; A suppresses it, B reports again.
    pixel(4'b0011, 11'd100, 11'd50);
    pixel(4'b0011, 11'd101, 11'd50);
    sof(99);
    repeat (10) step();
    chk("t2_A_q", qA.size(), 0);
    chk("t2_B_q", qB.size(), 0);

    // Three pairs in one pixel, reported in index order on consecutive cycles.
    popCycA.delete();
    pixel(4'b1110, 11'd200, 11'd300);
    sof(99);
    repeat (12) step();
    chk("t3_A_q", qA.size(), 0);
    chk("t3_B_q", qB.size(), 0);
    chk("t3_pops", popCycA.size(), 3);
    if (popCycA.size() == 3) begin
      chk("t3_consec1", popCycA[1] - popCycA[0], 1);
      chk("t3_consec2", popCycA[2] - popCycA[1], 1);
    end

    // Masked pair: channels 0,3 only reach instance A.
    pixel(4'b1001, 11'd7, 11'd9);
    sof(99);
    repeat (10) step();
    chk("t5_A_q", qA.size(), 0);
    chk("t5_B_q", qB.size(), 0);

    // Depth-2 FIFO stall, overflow on next boundary (set beats clear), then clear.
    readyB = 1'b0;
    pixel(4'b1111, 11'd10, 11'd20);
    sof(2);
    repeat (12) step();
    chk("t4_B_valid", bValid, 1);
    chk("t4_B_head", {7'd0, bPair, bX, bY}, pk(0, 11'd10, 11'd20));
    chk("t4_B_ovf0", bOverflow, 0);
    clearOverflow = 1'b1;
    sof(2);
    clearOverflow = 1'b0;
    chk("t4_B_ovf_setwins", bOverflow, 1);
    chk("t4_A_ovf", aOverflow, 0);
    clearOverflow = 1'b1;
    step();
    clearOverflow = 1'b0;
    chk("t4_B_ovf_clr", bOverflow, 0);
    readyB = 1'b1;
    repeat (12) step();
    chk("t4_B_q", qB.size(), 0);
    chk("t4_A_q", qA.size(), 0);

    // Boundary-cycle hit, then reset mid-scan with queued events.
    readyA = 1'b0; readyB = 1'b0;
    pixel(4'b1111, 11'd5, 11'd6);
    sof(2);
    repeat (2) step();
    sof(2);
    chk("t6_B_ovf", bOverflow, 1);
    step();
    chk("t6_A_valid_pre", aValid, 1);
    chk("t6_B_valid_pre", bValid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_A_valid", aValid, 0);
    chk("t6_A_fc", aFc, 0);
    chk("t6_A_ovf", aOverflow, 0);
    chk("t6_B_valid", bValid, 0);
    chk("t6_B_fc", bFc, 0);
    chk("t6_B_ovf", bOverflow, 0);
    modelClear();
    step();
    reset = 1'b0;
    readyA = 1'b1; readyB = 1'b1;
    step();

    // Randomized frames against the model.
    for (int f = 0; f < 20; f++) begin
      int nPix = $urandom_range(0, 4);
      for (int n = 0; n < nPix; n++) begin
        pixel(4'($urandom_range(0, 15)), 11'($urandom_range(0, 2047)),
              11'($urandom_range(0, 2047)));
        repeat ($urandom_range(0, 2)) step();
      end
      repeat (10) step();
      sof(99);
    end
    repeat (15) step();
    chk("rnd_A_q", qA.size(), 0);
    chk("rnd_B_q", qB.size(), 0);
    chk("rnd_A_ovf", aOverflow, 0);
    chk("rnd_B_ovf", bOverflow, 0);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
